// File: rtl/mcu_el2_dccm_bank_responder.sv
// rtl/mcu_el2_dccm_bank_responder.sv - DCCM bank memory responder with post-reset init sweep
module mcu_el2_dccm_bank_responder #(
  parameter int NUM_BANKS  = 4,
  parameter int INDEX_BITS = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0,
  parameter logic [ECC_WIDTH-1:0]  INIT_ECC  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_BANKS-1:0]             dccm_clken,
  input  logic [NUM_BANKS-1:0]             dccm_wren_bank,
  input  logic [NUM_BANKS*INDEX_BITS-1:0]  dccm_addr_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  dccm_wr_data_bank,
  input  logic [NUM_BANKS*ECC_WIDTH-1:0]   dccm_wr_ecc_bank,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  dccm_bank_dout,
  output logic [NUM_BANKS*ECC_WIDTH-1:0]   dccm_bank_ecc,
  output logic                             init_done,
  output logic                             init_req_err
);

  localparam int DEPTH  = 2 ** INDEX_BITS;
  localparam int WORD_W = DATA_WIDTH + ECC_WIDTH;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [INDEX_BITS-1:0]           init_idx_q, init_idx_d;
  logic                            init_req_err_q, init_req_err_d;
  logic [NUM_BANKS*DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NUM_BANKS*ECC_WIDTH-1:0]  ecc_q, ecc_d;

  // Each word is stored as {ecc, data}, passed through untouched.
  logic [WORD_W-1:0]     mem [NUM_BANKS][DEPTH];
  logic [NUM_BANKS-1:0]  mem_we;
  logic [INDEX_BITS-1:0] mem_addr  [NUM_BANKS];
  logic [WORD_W-1:0]     mem_wdata [NUM_BANKS];
  logic [WORD_W-1:0]     rd_word   [NUM_BANKS];

  // Sweep sequencing: walk every index once, then settle in READY; early requests flag an error.
  always_comb begin
    state_d        = state_q;
    init_idx_d     = init_idx_q;
    init_req_err_d = init_req_err_q;
    case (state_q)
      ST_INIT: begin
        if (init_idx_q == {INDEX_BITS{1'b1}}) begin
          state_d = ST_READY;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
        if (|dccm_clken) begin
          init_req_err_d = 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Per-bank port steering: the sweep owns every bank during INIT, the LSU owns them in READY.
  always_comb begin
    dout_d = dout_q;
    ecc_d  = ecc_q;
    mem_we = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      mem_addr[i]  = dccm_addr_bank[i*INDEX_BITS +: INDEX_BITS];
      mem_wdata[i] = {dccm_wr_ecc_bank[i*ECC_WIDTH +: ECC_WIDTH],
                      dccm_wr_data_bank[i*DATA_WIDTH +: DATA_WIDTH]};
      rd_word[i]   = mem[i][mem_addr[i]];
      if (state_q == ST_INIT) begin
        mem_we[i]    = 1'b1;
        mem_addr[i]  = init_idx_q;
        mem_wdata[i] = {INIT_ECC, INIT_DATA};
      end else if (dccm_clken[i]) begin
        if (dccm_wren_bank[i]) begin
          mem_we[i] = 1'b1;
        end else begin
          dout_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_word[i][DATA_WIDTH-1:0];
          ecc_d[i*ECC_WIDTH +: ECC_WIDTH]    = rd_word[i][WORD_W-1:DATA_WIDTH];
        end
      end
    end
  end

  // Control and output registers; reset restarts the sweep from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      init_idx_q     <= '0;
      init_req_err_q <= 1'b0;
      dout_q         <= '0;
      ecc_q          <= '0;
    end else begin
      state_q        <= state_d;
      init_idx_q     <= init_idx_d;
      init_req_err_q <= init_req_err_d;
      dout_q         <= dout_d;
      ecc_q          <= ecc_d;
    end
  end

  // Bank storage write ports; contents are not reset, the sweep provides the known state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (mem_we[i] && !rst) begin
        mem[i][mem_addr[i]] <= mem_wdata[i];
      end
    end
  end

  assign dccm_bank_dout = dout_q;
  assign dccm_bank_ecc  = ecc_q;
  assign init_done      = (state_q == ST_READY);
  assign init_req_err   = init_req_err_q;

endmodule

// File: tb/tb_mcu_el2_dccm_bank_responder.sv
// tb/tb_mcu_el2_dccm_bank_responder.sv - directed scoreboard bench for the DCCM bank responder
module tb_mcu_el2_dccm_bank_responder;

  localparam int NB    = 4;
  localparam int IB    = 6;
  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int DEPTH = 2 ** IB;
  localparam logic [DW-1:0] INIT_D = 32'h0BAD_F00D;
  localparam logic [EW-1:0] INIT_E = 7'h2C;

  logic                 clk;
  logic                 rst;
  logic [NB-1:0]        dccm_clken;
  logic [NB-1:0]        dccm_wren_bank;
  logic [NB*IB-1:0]     dccm_addr_bank;
  logic [NB*DW-1:0]     dccm_wr_data_bank;
  logic [NB*EW-1:0]     dccm_wr_ecc_bank;
  logic [NB*DW-1:0]     dccm_bank_dout;
  logic [NB*EW-1:0]     dccm_bank_ecc;
  logic                 init_done;
  logic                 init_req_err;

  mcu_el2_dccm_bank_responder #(
    .NUM_BANKS (NB),
    .INDEX_BITS(IB),
    .DATA_WIDTH(DW),
    .ECC_WIDTH (EW),
    .INIT_DATA (INIT_D),
    .INIT_ECC  (INIT_E)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dccm_clken       (dccm_clken),
    .dccm_wren_bank   (dccm_wren_bank),
    .dccm_addr_bank   (dccm_addr_bank),
    .dccm_wr_data_bank(dccm_wr_data_bank),
    .dccm_wr_ecc_bank (dccm_wr_ecc_bank),
    .dccm_bank_dout   (dccm_bank_dout),
    .dccm_bank_ecc    (dccm_bank_ecc),
    .init_done        (init_done),
    .init_req_err     (init_req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            bank;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } exp_t;

  exp_t          sb[$];
  logic [DW+EW-1:0] model [NB][DEPTH];
  logic [DW-1:0] exp_d [NB];
  logic [EW-1:0] exp_e [NB];
  int            init_cnt;
  logic          err_m;
  int            n_cmp;
  int            n_mis;
  int            steps_since_release;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bank(input int b, input logic we, input logic [IB-1:0] idx,
                          input logic [DW-1:0] d, input logic [EW-1:0] e);
    exp_t x;
    dccm_clken[b]                 = 1'b1;
    dccm_wren_bank[b]             = we;
    dccm_addr_bank[b*IB +: IB]    = idx;
    dccm_wr_data_bank[b*DW +: DW] = d;
    dccm_wr_ecc_bank[b*EW +: EW]  = e;
    if (init_cnt >= DEPTH) begin
      if (we) begin
        model[b][idx] = {e, d};
      end else begin
        x.bank = b;
        x.d    = model[b][idx][DW-1:0];
        x.e    = model[b][idx][DW+EW-1:DW];
        sb.push_back(x);
      end
    end
  endtask

  task automatic step();
    logic was_rst;
    logic was_ready;
    logic any_en;
    exp_t x;
    was_rst   = rst;
    was_ready = (init_cnt >= DEPTH);
    any_en    = |dccm_clken;
    @(posedge clk);
    #1;
    if (was_rst) begin
      init_cnt = 0;
      err_m    = 1'b0;
      sb.delete();
      for (int b = 0; b < NB; b++) begin
        exp_d[b] = '0;
        exp_e[b] = '0;
        for (int k = 0; k < DEPTH; k++) model[b][k] = {INIT_E, INIT_D};
      end
    end else begin
      if (!was_ready) begin
        init_cnt++;
        if (any_en) err_m = 1'b1;
      end
      while (sb.size() > 0) begin
        x = sb.pop_front();
        exp_d[x.bank] = x.d;
        exp_e[x.bank] = x.e;
      end
    end
    for (int b = 0; b < NB; b++) begin
      check($sformatf("dout%0d", b), 64'(dccm_bank_dout[b*DW +: DW]), 64'(exp_d[b]));
      check($sformatf("ecc%0d", b), 64'(dccm_bank_ecc[b*EW +: EW]), 64'(exp_e[b]));
    end
    check("init_done", 64'(init_done), 64'(init_cnt >= DEPTH));
    check("init_req_err", 64'(init_req_err), 64'(err_m));
    dccm_clken     = '0;
    dccm_wren_bank = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    init_cnt = DEPTH;
    err_m = 1'b0;
    rst = 1'b1;
    dccm_clken = '0;
    dccm_wren_bank = '0;
    dccm_addr_bank = '0;
    dccm_wr_data_bank = '0;
    dccm_wr_ecc_bank = '0;

    // reset state
    step();
    step();
    check("reset_dout", 64'(dccm_bank_dout[63:0]), 64'h0);
    rst = 1'b0;

    // first sweep: early write at cycle 2 to an already-swept index, then reset at cycle 7
    step();
    step();
    set_bank(3, 1'b1, 6'd1, 32'hFFFF_0000, 7'h7F);
    step();
    check("early_err_set", 64'(init_req_err), 64'h1);
    for (int k = 3; k < 7; k++) step();
    rst = 1'b1;
    step();
    check("err_cleared_by_rst", 64'(init_req_err), 64'h0);
    rst = 1'b0;

    // second sweep with another early access; init_done must rise exactly DEPTH edges after release
    steps_since_release = 0;
    step();
    step();
    steps_since_release = 2;
    set_bank(3, 1'b1, 6'd1, 32'hFFFF_0000, 7'h7F);
    step();
    steps_since_release++;
    for (int k = 0; k < 200 && init_cnt < DEPTH; k++) begin
      step();
      steps_since_release++;
    end
    check("init_rise_cycle", 64'(steps_since_release), 64'(DEPTH));
    check("init_done_high", 64'(init_done), 64'h1);
    check("err_sticky", 64'(init_req_err), 64'h1);

    // sweep contents, including the location targeted early
    for (int b = 0; b < NB; b++) set_bank(b, 1'b0, 6'd0, '0, '0);
    step();
    check("sweep_b0_idx0", 64'(dccm_bank_dout[DW-1:0]), 64'(INIT_D));
    for (int b = 0; b < NB; b++) set_bank(b, 1'b0, 6'd63, '0, '0);
    step();
    set_bank(3, 1'b0, 6'd1, '0, '0);
    set_bank(1, 1'b0, 6'd17, '0, '0);
    step();
    check("early_loc_untouched", 64'(dccm_bank_dout[3*DW +: DW]), 64'(INIT_D));

    // bank 2 write then read of 0x3A
    set_bank(2, 1'b1, 6'h3A, 32'hDEAD_BEEF, 7'h55);
    step();
    set_bank(2, 1'b0, 6'h3A, '0, '0);
    step();
    check("b2_deadbeef", 64'(dccm_bank_dout[2*DW +: DW]), 64'hDEAD_BEEF);
    check("b2_ecc55", 64'(dccm_bank_ecc[2*EW +: EW]), 64'h55);
    step();

    // misaligned lo/hi pair written and read together
    set_bank(1, 1'b1, 6'd5, 32'h1111_1111, 7'h11);
    set_bank(2, 1'b1, 6'd6, 32'h2222_2222, 7'h22);
    step();
    set_bank(1, 1'b0, 6'd5, '0, '0);
    set_bank(2, 1'b0, 6'd6, '0, '0);
    step();
    check("pair_b1", 64'(dccm_bank_dout[1*DW +: DW]), 64'h1111_1111);
    check("pair_b2", 64'(dccm_bank_dout[2*DW +: DW]), 64'h2222_2222);

    // wren without clken must be ignored
    dccm_wren_bank[1] = 1'b1;
    dccm_addr_bank[1*IB +: IB] = 6'd5;
    dccm_wr_data_bank[1*DW +: DW] = 32'hBAD0_BAD0;
    step();
    set_bank(1, 1'b0, 6'd5, '0, '0);
    step();

    // output hold across idle cycles and a write to the same bank
    set_bank(0, 1'b1, 6'd9, 32'hA5A5_A5A5, 7'h5A);
    step();
    set_bank(0, 1'b0, 6'd9, '0, '0);
    step();
    for (int k = 0; k < 5; k++) step();
    set_bank(0, 1'b1, 6'd9, 32'h1234_5678, 7'h01);
    step();
    check("hold_b0", 64'(dccm_bank_dout[DW-1:0]), 64'hA5A5_A5A5);
    set_bank(0, 1'b0, 6'd9, '0, '0);
    step();

    // mixed read/write mix across all banks, then random traffic
    set_bank(0, 1'b0, 6'h3A, '0, '0);
    set_bank(1, 1'b1, 6'd40, 32'hCAFE_0001, 7'h33);
    set_bank(2, 1'b0, 6'h3A, '0, '0);
    set_bank(3, 1'b1, 6'd41, 32'hCAFE_0003, 7'h44);
    step();
    set_bank(1, 1'b0, 6'd40, '0, '0);
    set_bank(3, 1'b0, 6'd41, '0, '0);
    step();
    for (int k = 0; k < 60; k++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 2) != 0)
          set_bank(b, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom(), 7'($urandom()));
      end
      step();
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mcu_el2_dccm_bank_responder.md
# mcu_el2_dccm_bank_responder

Memory-side responder for the exported DCCM bank interface: it receives per-bank clock-enable, write-enable, index, data and ECC from the LSU DCCM controller and returns per-bank read data and ECC with one-cycle latency. It holds NUM_BANKS single-ported banks. After reset it runs a hardware initialisation sweep that writes a known data/ECC pattern to every location. It sits in the testbench/SoC memory wrapper, at the far end of the `mcu_el2_mem_if` DCCM signals.

## Interface
- NUM_BANKS, 4, number of DCCM banks (power of two, 2..8).
- INDEX_BITS, 10, per-bank index width; bank depth = 2**INDEX_BITS.
- DATA_WIDTH, 32, data bits per bank word.
- ECC_WIDTH, 7, ECC bits per bank word.
- INIT_DATA, 0, data value written by the init sweep.
- INIT_ECC, 0, ECC value written by the init sweep.

Ports (clock and reset first):
- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- dccm_clken  in  NUM_BANKS  per-bank access enable.
- dccm_wren_bank  in  NUM_BANKS  per-bank write enable; meaningful only with the matching clken.
- dccm_addr_bank  in  NUM_BANKS*INDEX_BITS  per-bank word index; bank i occupies slice i.
- dccm_wr_data_bank  in  NUM_BANKS*DATA_WIDTH  per-bank write data.
- dccm_wr_ecc_bank  in  NUM_BANKS*ECC_WIDTH  per-bank write ECC.
- dccm_bank_dout  out  NUM_BANKS*DATA_WIDTH  per-bank registered read data.
- dccm_bank_ecc  out  NUM_BANKS*ECC_WIDTH  per-bank registered read ECC.
- init_done  out  1  high once the init sweep has completed.
- init_req_err  out  1  sticky; set if any clken is asserted before init_done.

## Operation
- Storage: NUM_BANKS arrays, each 2**INDEX_BITS words of DATA_WIDTH+ECC_WIDTH bits. Data and ECC are stored and returned verbatim; there is no checking or correction in this block.
- FSM states: INIT, READY.
  - rst forces INIT with init_idx=0.
  - In INIT, every clock writes {INIT_ECC, INIT_DATA} to word init_idx in all banks, then increments init_idx.
  - When init_idx == 2**INDEX_BITS-1 is written, the FSM goes to READY. READY is terminal until rst.
- init_idx is an INDEX_BITS-wide counter. The terminal compare happens before increment, so there is no wrap.
- Functional accesses (READY only), evaluated independently per bank i:
  - clken[i] & wren[i]: write {wr_ecc, wr_data} to addr[i]. dout[i]/ecc[i] hold their previous value.
  - clken[i] & ~wren[i]: read addr[i]. dout[i]/ecc[i] update on the next edge.
  - ~clken[i]: no access; outputs hold.
  - wren without clken is ignored.
- Banks are single-ported: a write and a read can never target the same bank in one cycle, because wren selects the operation.
- Several banks may be accessed in the same cycle, in any read/write mix. This covers the misaligned lo/hi two-bank case.
- Requests while in INIT:
  - The request is ignored; storage is written only by the sweep and outputs hold.
  - init_req_err is set and stays set until rst.
- Reset mid-operation: rst in any state, including partway through INIT, restarts the sweep from index 0. Contents written before the reset are overwritten by the new sweep.

## Timing
- Reset values: dccm_bank_dout=0, dccm_bank_ecc=0, init_done=0, init_req_err=0, state=INIT, init_idx=0.
- Let cycle 0 be the first edge with rst low. Index k is written at edge k.
- init_done rises after edge 2**INDEX_BITS-1, so it is visible during cycle 2**INDEX_BITS. The first functional request is accepted in that cycle.
- Read latency: 1 cycle. A request presented in cycle n gives data on the outputs in cycle n+1, and the data holds until the next read of that bank.
- Write-then-read of the same address in consecutive cycles returns the new data (the write completes at edge n).
- init_req_err sets at the edge that samples the offending clken and is visible in the next cycle.

## Test plan
- Reset release, INDEX_BITS=4: init_done=0 for 16 cycles, then 1; reading any index in any bank returns data=INIT_DATA, ecc=INIT_ECC one cycle later.
- Bank 2, index 0x3A: write data 0xDEADBEEF, ecc 0x55; next cycle read the same index -> the following cycle dout[2]=0xDEADBEEF, ecc[2]=0x55; other banks' outputs unchanged.
- Misaligned pair in one cycle: write bank 1 idx 5 = 0x11111111 and bank 2 idx 6 = 0x22222222; then read both together -> both values appear in the same cycle on their respective bank outputs.
- Output hold: read bank 0 giving 0xA5A5A5A5, then deassert clken for 5 cycles and write bank 0 once -> dout[0] stays 0xA5A5A5A5 throughout.
- Early access: assert clken[3] with wren at cycle 2 of INIT -> init_req_err=1 from cycle 3 until rst; after init, that location reads INIT_DATA.
- Reset mid-sweep: assert rst at cycle 7 of INIT, release -> the sweep restarts at index 0; init_done rises exactly 2**INDEX_BITS cycles after release.
